// File: rtl/disp_bcd_conv_if.sv
// Handshake and result bundle between a conversion requester and disp_bcd_conv.
// The requester drives start/bin; the converter returns busy/done/bcd/ovf.
interface disp_bcd_conv_if;
  logic        start;
  logic [26:0] bin;
  logic        busy;
  logic        done;
  logic [31:0] bcd;
  logic        ovf;

  modport master (output start, bin, input busy, done, bcd, ovf);
  modport slave  (input start, bin, output busy, done, bcd, ovf);
endinterface

// File: rtl/disp_bcd_conv.sv
// 27-bit binary to 8-digit packed BCD converter (shift-and-add-3, one bit per cycle).
// Define DISP_BCD_SAT_EN to clamp out-of-range values to 99999999 instead of wrapping.
module disp_bcd_conv (
  input  logic             clk,
  input  logic             reset,
  disp_bcd_conv_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  localparam logic [26:0] BCD_MAX  = 27'd99_999_999;
  localparam logic [4:0]  LAST_CNT = 5'd26;
`ifdef DISP_BCD_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [26:0] shift_q, shift_d;
  logic [31:0] work_q, work_d;
  logic [31:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;
  logic        ovf_cap_q, ovf_cap_d;
  logic [31:0] adj;
  logic [31:0] next_work;

  // Each digit >= 5 gets +3 so the following left shift carries correctly in decimal.
  function automatic logic [31:0] add3(input logic [31:0] w);
    logic [31:0] r;
    r = w;
    for (int i = 0; i < 8; i++) begin
      if (w[4*i +: 4] >= 4'd5) r[4*i +: 4] = w[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [31:0] saturate(input logic [31:0] w, input logic ovf);
    return (SAT_EN && ovf) ? 32'h9999_9999 : w;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    work_d    = work_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    ovf_cap_d = ovf_cap_q;
    adj       = add3(work_q);
    next_work = {adj[30:0], shift_q[26]};

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          shift_d   = bus.bin;
          work_d    = '0;
          cnt_d     = '0;
          ovf_cap_d = (bus.bin > BCD_MAX);
          state_d   = CONV;
        end else begin
          state_d   = IDLE;
        end
      end
      CONV: begin
        work_d  = next_work;
        shift_d = {shift_q[25:0], 1'b0};
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          bcd_d   = saturate(next_work, ovf_cap_q);
          ovf_d   = ovf_cap_q;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      work_q    <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      ovf_cap_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      work_q    <= work_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      ovf_cap_q <= ovf_cap_d;
    end
  end

  assign bus.busy = (state_q == CONV);
  assign bus.done = (state_q == DONE);
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_disp_bcd_conv.sv
// Scoreboard bench for disp_bcd_conv: driver pushes expected results, a monitor
// pops one entry per done pulse; reference converts with decimal arithmetic.
module tb_disp_bcd_conv;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [32:0] exp_q[$];
  logic [31:0] last_bcd = '0;

  disp_bcd_conv_if bus();

  disp_bcd_conv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] ref_result(input logic [26:0] b);
    longint v;
    logic [31:0] r;
    logic        ovf;
    v   = longint'(b);
    ovf = (v > 64'd99_999_999);
`ifdef DISP_BCD_SAT_EN
    if (ovf) v = 99_999_999;
`endif
    v = v % 100_000_000;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return {ovf, r};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (bus.busy === 1'b1) check("bcd_stable_in_conv", 64'(bus.bcd), 64'(last_bcd));
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got bcd=%h with no outstanding request", bus.bcd);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("bcd", 64'(bus.bcd), 64'(e[31:0]));
          check("ovf", 64'(bus.ovf), 64'(e[32]));
        end
        last_bcd = bus.bcd;
      end
    end
  end

  // One conversion; optional stray start at busy cycle intr_at, optional reset at busy cycle rst_at.
  task automatic conv(input logic [26:0] b, input int intr_at, input int rst_at);
    int cnt;
    bit seen;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.bin   = b;
    exp_q.push_back(ref_result(b));
    @(posedge clk); #1;
    bus.start = 1'b0;
    cnt  = 0;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1;
      end else if (bus.busy === 1'b1) begin
        cnt++;
        bus.bin = 27'($urandom);
        if (cnt == intr_at) bus.start = 1'b1;
        else if (cnt == intr_at + 1) bus.start = 1'b0;
        if (cnt == rst_at) begin
          reset = 1'b0;
          #1;
          check("rst_busy", 64'(bus.busy), 64'd0);
          check("rst_done", 64'(bus.done), 64'd0);
          check("rst_bcd", 64'(bus.bcd), 64'd0);
          check("rst_ovf", 64'(bus.ovf), 64'd0);
          exp_q.delete();
          last_bcd = '0;
          @(negedge clk);
          reset = 1'b1;
          return;
        end
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done, expected one within 60 cycles");
    end else begin
      check("busy_cycles", 64'(cnt), 64'd27);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_busy", 64'(bus.busy), 64'd0);
    end
  endtask

  initial begin
    int gap;
    bit seen2;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.bin   = '0;
    #12;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_bcd", 64'(bus.bcd), 64'd0);
    check("reset_ovf", 64'(bus.ovf), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    conv(27'd12_345_678, 0, 0);
    conv(27'd0, 0, 0);
    conv(27'd99_999_999, 0, 0);
    conv(27'd134_217_727, 0, 0);
    conv(27'd100_000_000, 0, 0);

    // Stray start mid-conversion must be ignored.
    conv(27'd87_654_321, 10, 0);
    idle_cycles(40);

    // Back-to-back with start held high.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.bin   = 27'd5;
    exp_q.push_back(ref_result(27'd5));
    exp_q.push_back(ref_result(27'd42));
    @(posedge clk); #1;
    bus.bin = 27'd42;
    seen2 = 0;
    for (int i = 0; i < 60 && !seen2; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen2 = 1;
    end
    check("b2b_first_done", 64'(seen2), 64'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    gap   = 1;
    seen2 = 0;
    for (int i = 0; i < 60 && !seen2; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen2 = 1;
      else gap++;
    end
    check("b2b_period", 64'(gap), 64'd28);
    idle_cycles(5);

    // Reset in the middle of a conversion, then a clean conversion.
    conv(27'd76_543_210, 0, 13);
    idle_cycles(35);
    conv(27'd31_415_926, 0, 0);

    for (int k = 0; k < 8; k++) begin
      logic [26:0] r;
      r = 27'($urandom);
      if (k % 2 == 0) r = 27'($urandom_range(99_999_999, 0));
      conv(r, 0, 0);
    end

    idle_cycles(3);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
